// File: rtl/bcd_scan_driver.sv
// bcd_scan_driver: four-digit BCD up/down counter with a multiplexed
// scanner feeding one HC4511 decoder/latch and common-cathode digit selects.
module bcd_scan_driver #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned LZB      = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        INC,
  input  logic        UP,
  input  logic        CLR,
  input  logic        LT_REQ_N,
  output logic [3:0]  A,
  output logic        LE,
  output logic        BI_N,
  output logic        LT_N,
  output logic [3:0]  DIG_N,
  output logic [15:0] COUNT,
  output logic        OVF
);

  typedef enum logic [1:0] {
    ST_BLANK,
    ST_LOAD,
    ST_SHOW
  } phase_t;

  localparam logic [15:0] P_LAST = 16'(SCAN_DIV - 1);

  phase_t      state;
  phase_t      state_nxt;
  logic [15:0] p;
  logic [15:0] p_nxt;
  logic [1:0]  k;
  logic [1:0]  k_nxt;

  logic [15:0] count_nxt;
  logic        carry;

  logic        lz;
  logic        lz_calc;
  logic        lz_d;
  logic [3:0]  a_d;
  logic        le_d;
  logic        bi_n_d;
  logic [3:0]  dig_n_d;

  // Ripple the +1/-1 through the nibbles; carry survives only on a full wrap
  always_comb begin
    count_nxt = COUNT;
    carry     = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (carry) begin
        if (UP) begin
          if (COUNT[4*i +: 4] == 4'd9) begin
            count_nxt[4*i +: 4] = 4'd0;
          end else begin
            count_nxt[4*i +: 4] = COUNT[4*i +: 4] + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (COUNT[4*i +: 4] == 4'd0) begin
            count_nxt[4*i +: 4] = 4'd9;
          end else begin
            count_nxt[4*i +: 4] = COUNT[4*i +: 4] - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  // Counter register: clear wins over counting, OVF flags the wrap cycle
  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      COUNT <= '0;
      OVF   <= 1'b0;
    end else if (INC) begin
      COUNT <= count_nxt;
      OVF   <= carry;
    end else begin
      OVF   <= 1'b0;
    end
  end

  // Scanner state register: phase, phase counter and digit index
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_BLANK;
      p     <= '0;
      k     <= '0;
    end else begin
      state <= state_nxt;
      p     <= p_nxt;
      k     <= k_nxt;
    end
  end

  // Next-state: BLANK -> LOAD -> SHOW... -> BLANK of the following digit
  always_comb begin
    state_nxt = state;
    p_nxt     = p + 16'd1;
    k_nxt     = k;
    case (state)
      ST_BLANK: state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_SHOW;
      ST_SHOW: begin
        if (p == P_LAST) begin
          state_nxt = ST_BLANK;
          p_nxt     = '0;
          k_nxt     = k + 2'd1;
        end
      end
      default: begin
        state_nxt = ST_BLANK;
        p_nxt     = '0;
        k_nxt     = '0;
      end
    endcase
  end

  // Leading-zero test for the digit about to be loaded: it and all higher nibbles are 0
  always_comb begin
    lz_calc = 1'b0;
    if (k_nxt != 2'd0) begin
      lz_calc = 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
        if (i >= 32'(k_nxt) && COUNT[4*i +: 4] != 4'd0) begin
          lz_calc = 1'b0;
        end
      end
    end
  end

  // Outputs are registered, so decode the phase being entered, not the current one
  always_comb begin
    a_d     = A;
    le_d    = 1'b1;
    bi_n_d  = 1'b0;
    dig_n_d = '1;
    lz_d    = lz;
    case (state_nxt)
      ST_LOAD: begin
        a_d    = COUNT[4*k_nxt +: 4];
        le_d   = 1'b0;
        bi_n_d = 1'b1;
        lz_d   = lz_calc;
      end
      ST_SHOW: begin
        dig_n_d = ~(4'b0001 << k_nxt);
        bi_n_d  = !((LZB != 0) && lz && LT_REQ_N);
      end
      default: ;
    endcase
  end

  // Output register stage
  always_ff @(posedge CLK) begin
    if (RST) begin
      A     <= '0;
      LE    <= 1'b1;
      BI_N  <= 1'b0;
      LT_N  <= 1'b1;
      DIG_N <= '1;
      lz    <= 1'b0;
    end else begin
      A     <= a_d;
      LE    <= le_d;
      BI_N  <= bi_n_d;
      LT_N  <= LT_REQ_N;
      DIG_N <= dig_n_d;
      lz    <= lz_d;
    end
  end

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Self-checking bench for bcd_scan_driver: two instances (LZB=1, LZB=0)
// share stimulus and are compared against an arithmetic reference model.
module tb_bcd_scan_driver;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inc = 1'b0;
  logic        up = 1'b1;
  logic        clr = 1'b0;
  logic        lt_req_n = 1'b1;

  logic [3:0]  a1, dig1, a0, dig0;
  logic        le1, bi1, lt1, ovf1, le0, bi0, lt0, ovf0;
  logic [15:0] cnt1, cnt0;

  int errors = 0;
  int checks = 0;

  // reference model state
  int m_cnt = 0;
  int m_t   = 0;
  int m_a   = 0;
  bit m_ovf = 1'b0;
  bit m_lz  = 1'b0;
  bit m_lt  = 1'b1;
  int p10 [4] = '{1, 10, 100, 1000};

  always #5 clk = ~clk;

  bcd_scan_driver #(.SCAN_DIV(SD), .LZB(1)) dut_lzb (
    .CLK(clk), .RST(rst), .INC(inc), .UP(up), .CLR(clr), .LT_REQ_N(lt_req_n),
    .A(a1), .LE(le1), .BI_N(bi1), .LT_N(lt1), .DIG_N(dig1), .COUNT(cnt1), .OVF(ovf1)
  );

  bcd_scan_driver #(.SCAN_DIV(SD), .LZB(0)) dut_nolz (
    .CLK(clk), .RST(rst), .INC(inc), .UP(up), .CLR(clr), .LT_REQ_N(lt_req_n),
    .A(a0), .LE(le0), .BI_N(bi0), .LT_N(lt0), .DIG_N(dig0), .COUNT(cnt0), .OVF(ovf0)
  );

  // Model: count as an integer 0..9999, display derived from cycles since reset
  always @(posedge clk) begin
    int old_cnt, ph, kk;
    if (rst) begin
      m_cnt = 0; m_ovf = 1'b0; m_t = 0; m_a = 0; m_lz = 1'b0; m_lt = 1'b1;
    end else begin
      old_cnt = m_cnt;
      m_t = m_t + 1;
      ph = m_t % SD;
      kk = (m_t / SD) % 4;
      if (ph == 1) begin
        m_a  = (old_cnt / p10[kk]) % 10;
        m_lz = (kk != 0) && (old_cnt < p10[kk]);
      end
      m_lt = lt_req_n;
      if (clr) begin
        m_cnt = 0; m_ovf = 1'b0;
      end else if (inc) begin
        if (up) begin
          m_ovf = (old_cnt == 9999);
          m_cnt = (old_cnt + 1) % 10000;
        end else begin
          m_ovf = (old_cnt == 0);
          m_cnt = (old_cnt + 9999) % 10000;
        end
      end else begin
        m_ovf = 1'b0;
      end
    end
  end

  function automatic logic [15:0] to_bcd(int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  // expected {A, LE, BI_N, DIG_N}
  function automatic logic [9:0] exp_disp(bit lzb);
    int ph, kk;
    logic [3:0] dsel;
    logic bi;
    ph = m_t % SD;
    kk = (m_t / SD) % 4;
    if (ph == 0) return {4'(m_a), 1'b1, 1'b0, 4'b1111};
    if (ph == 1) return {4'(m_a), 1'b0, 1'b1, 4'b1111};
    dsel = ~(4'b0001 << kk);
    bi = !(lzb && m_lz && m_lt);
    return {4'(m_a), 1'b1, bi, dsel};
  endfunction

  task automatic test_reset();
    rst = 1'b1; inc = 1'b0; clr = 1'b0; up = 1'b1; lt_req_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({a1, le1, bi1, lt1, dig1, cnt1, ovf1} !== {4'h0, 1'b1, 1'b0, 1'b1, 4'hF, 16'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_lzb got=%b exp=%b", {a1, le1, bi1, lt1, dig1, cnt1, ovf1},
               {4'h0, 1'b1, 1'b0, 1'b1, 4'hF, 16'h0, 1'b0});
    end
    checks++;
    if ({a0, le0, bi0, lt0, dig0, cnt0, ovf0} !== {4'h0, 1'b1, 1'b0, 1'b1, 4'hF, 16'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_nolz got=%b exp=%b", {a0, le0, bi0, lt0, dig0, cnt0, ovf0},
               {4'h0, 1'b1, 1'b0, 1'b1, 4'hF, 16'h0, 1'b0});
    end
    rst = 1'b0;
  endtask

  task automatic test_idle_scan();
    int units_cycles = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (dig1 == 4'b1110) units_cycles++;
      checks++;
      if ({a1, le1, bi1, dig1} !== exp_disp(1'b1)) begin
        errors++;
        $display("FAIL idle_disp_lzb t=%0d got=%b exp=%b", m_t, {a1, le1, bi1, dig1}, exp_disp(1'b1));
      end
      checks++;
      if ({a0, le0, bi0, dig0} !== exp_disp(1'b0)) begin
        errors++;
        $display("FAIL idle_disp_nolz t=%0d got=%b exp=%b", m_t, {a0, le0, bi0, dig0}, exp_disp(1'b0));
      end
    end
    checks++;
    if (units_cycles !== 4) begin
      errors++;
      $display("FAIL idle_units_slots got=%0d exp=4", units_cycles);
    end
  endtask

  task automatic test_increment();
    int  pulses = 0;
    bit  saw_0010 = 1'b0, saw_0100 = 1'b0;
    logic [15:0] prev;
    prev = cnt1;
    inc = 1'b1; up = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (ovf1) pulses++;
      if (prev == 16'h0009 && cnt1 == 16'h0010) saw_0010 = 1'b1;
      if (prev == 16'h0099 && cnt1 == 16'h0100) saw_0100 = 1'b1;
      prev = cnt1;
      checks++;
      if ({cnt1, ovf1} !== {to_bcd(m_cnt), m_ovf}) begin
        errors++;
        $display("FAIL inc_count t=%0d got=%h/%b exp=%h/%b", m_t, cnt1, ovf1, to_bcd(m_cnt), m_ovf);
      end
      checks++;
      if ({a1, le1, bi1, dig1} !== exp_disp(1'b1)) begin
        errors++;
        $display("FAIL inc_disp_lzb t=%0d got=%b exp=%b", m_t, {a1, le1, bi1, dig1}, exp_disp(1'b1));
      end
      checks++;
      if ({a0, le0, bi0, dig0} !== exp_disp(1'b0)) begin
        errors++;
        $display("FAIL inc_disp_nolz t=%0d got=%b exp=%b", m_t, {a0, le0, bi0, dig0}, exp_disp(1'b0));
      end
    end
    inc = 1'b0;
    checks++;
    if (pulses !== 1 || cnt1 !== 16'h0000) begin
      errors++;
      $display("FAIL inc_wrap pulses=%0d count=%h exp pulses=1 count=0000", pulses, cnt1);
    end
    checks++;
    if (!(saw_0010 && saw_0100)) begin
      errors++;
      $display("FAIL inc_carry saw0010=%0b saw0100=%0b exp=1/1", saw_0010, saw_0100);
    end
  endtask

  task automatic test_decrement();
    int loads = 0, bad = 0;
    inc = 1'b1; up = 1'b0;
    @(negedge clk);
    inc = 1'b0;
    checks++;
    if ({cnt1, ovf1} !== {16'h9999, 1'b1}) begin
      errors++;
      $display("FAIL dec_wrap got=%h/%b exp=9999/1", cnt1, ovf1);
    end
    @(negedge clk);
    checks++;
    if (ovf1 !== 1'b0) begin
      errors++;
      $display("FAIL dec_ovf_width got=%b exp=0", ovf1);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (le1 == 1'b0) begin
        loads++;
        if (a1 != 4'd9) bad++;
      end
      checks++;
      if ({a1, le1, bi1, dig1} !== exp_disp(1'b1)) begin
        errors++;
        $display("FAIL dec_disp t=%0d got=%b exp=%b", m_t, {a1, le1, bi1, dig1}, exp_disp(1'b1));
      end
    end
    checks++;
    if (loads < 4 || bad != 0) begin
      errors++;
      $display("FAIL dec_loads loads=%0d non9=%0d exp >=4 and 0", loads, bad);
    end
  endtask

  task automatic test_clear();
    int show1 = 0, show0 = 0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; inc = 1'b1; up = 1'b1;
    repeat (1234) @(negedge clk);
    inc = 1'b0;
    checks++;
    if (cnt1 !== 16'h1234) begin
      errors++;
      $display("FAIL clr_setup got=%h exp=1234", cnt1);
    end
    clr = 1'b1; inc = 1'b1;
    @(negedge clk);
    clr = 1'b0; inc = 1'b0;
    checks++;
    if ({cnt1, ovf1, cnt0, ovf0} !== {16'h0, 1'b0, 16'h0, 1'b0}) begin
      errors++;
      $display("FAIL clr_priority got=%h/%b exp=0000/0", cnt1, ovf1);
    end
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      if (i >= 20 && dig1 != 4'b1111 && bi1) show1++;
      if (i >= 20 && dig0 != 4'b1111 && bi0 && a0 == 4'd0) show0++;
      checks++;
      if ({a1, le1, bi1, dig1} !== exp_disp(1'b1)) begin
        errors++;
        $display("FAIL clr_disp_lzb t=%0d got=%b exp=%b", m_t, {a1, le1, bi1, dig1}, exp_disp(1'b1));
      end
      checks++;
      if ({a0, le0, bi0, dig0} !== exp_disp(1'b0)) begin
        errors++;
        $display("FAIL clr_disp_nolz t=%0d got=%b exp=%b", m_t, {a0, le0, bi0, dig0}, exp_disp(1'b0));
      end
    end
    checks++;
    if (show1 !== 2 || show0 !== 8) begin
      errors++;
      $display("FAIL clr_blanking lit_lzb=%0d lit_nolz=%0d exp 2 and 8", show1, show0);
    end
  endtask

  task automatic test_lamp();
    int lit = 0;
    bit [3:0] seen = '0;
    inc = 1'b1; up = 1'b1;
    repeat (5) @(negedge clk);
    inc = 1'b0; lt_req_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({cnt1, lt1} !== {16'h0005, 1'b0}) begin
      errors++;
      $display("FAIL lamp_lt got=%h/%b exp=0005/0", cnt1, lt1);
    end
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      if (i >= 20 && dig1 != 4'b1111) begin
        if (bi1) lit++;
        seen = seen | ~dig1;
      end
      checks++;
      if ({a1, le1, bi1, dig1} !== exp_disp(1'b1)) begin
        errors++;
        $display("FAIL lamp_disp t=%0d got=%b exp=%b", m_t, {a1, le1, bi1, dig1}, exp_disp(1'b1));
      end
    end
    lt_req_n = 1'b1;
    checks++;
    if (lit !== 8 || seen !== 4'b1111) begin
      errors++;
      $display("FAIL lamp_scan lit=%0d digits=%b exp 8 and 1111", lit, seen);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      checks++;
      if ({cnt1, ovf1, lt1} !== {to_bcd(m_cnt), m_ovf, m_lt}) begin
        errors++;
        $display("FAIL rnd_count t=%0d got=%h/%b/%b exp=%h/%b/%b", m_t, cnt1, ovf1, lt1,
                 to_bcd(m_cnt), m_ovf, m_lt);
      end
      checks++;
      if ({a1, le1, bi1, dig1} !== exp_disp(1'b1)) begin
        errors++;
        $display("FAIL rnd_disp_lzb t=%0d got=%b exp=%b", m_t, {a1, le1, bi1, dig1}, exp_disp(1'b1));
      end
      checks++;
      if ({a0, le0, bi0, dig0} !== exp_disp(1'b0)) begin
        errors++;
        $display("FAIL rnd_disp_nolz t=%0d got=%b exp=%b", m_t, {a0, le0, bi0, dig0}, exp_disp(1'b0));
      end
      inc      = ($urandom_range(0, 3) != 0);
      up       = ($urandom_range(0, 7) != 0) ? (i % 600 < 300) : $urandom_range(0, 1) != 0;
      clr      = ($urandom_range(0, 63) == 0);
      lt_req_n = ($urandom_range(0, 15) != 0);
    end
    inc = 1'b0; clr = 1'b0; lt_req_n = 1'b1; up = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    inc = 1'b1;
    repeat (3) @(negedge clk);
    inc = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if ((m_t % SD) >= 2 && ((m_t / SD) % 4) == 2) found = 1'b1;
    end
    checks++;
    if (!found || dig1 !== 4'b1011) begin
      errors++;
      $display("FAIL rstmid_reach found=%0b dig=%b exp 1/1011", found, dig1);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({a1, le1, bi1, lt1, dig1, cnt1, ovf1} !== {4'h0, 1'b1, 1'b0, 1'b1, 4'hF, 16'h0, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_vals got=%b exp=%b", {a1, le1, bi1, lt1, dig1, cnt1, ovf1},
               {4'h0, 1'b1, 1'b0, 1'b1, 4'hF, 16'h0, 1'b0});
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({a1, le1, bi1, dig1} !== exp_disp(1'b1)) begin
        errors++;
        $display("FAIL rstmid_disp t=%0d got=%b exp=%b", m_t, {a1, le1, bi1, dig1}, exp_disp(1'b1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_increment();
    test_decrement();
    test_clear();
    test_lamp();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
